// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the byte/status outputs of uart_rx.
// master drives the line and watches results; slave is the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  modport master (output rx, input data, valid, busy, frame_err, parity_err);
  modport slave  (input rx, output data, valid, busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Define UART_RX_PARITY_EN for 8E1 frames
// with an even-parity check reported on parity_err.
// Bits are sampled at their midpoint by a clock-count timer; a byte is
// published with a one-cycle valid when its stop bit samples high.
module uart_rx #(
  parameter int CLOCK_RATE     = 10,
  parameter int BAUD_RATE      = 1,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  generate
    if (CLOCKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx: CLOCKS_PER_BIT must be >= 4");
    end
  endgenerate

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLOCKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          valid_q, busy_q, ferr_q, perr_q;
  logic          rx_m, rx_s, rx_d;
`ifdef UART_RX_PARITY_EN
  logic          par;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Frame state machine with registered status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bidx    <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          // Edge-triggered: a line stuck low after a framing error never restarts.
          if (rx_d && !rx_s) begin
            timer <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          busy_q <= 1'b1;
          if (timer == HALF) begin
            if (!rx_s) begin
              timer <= '0;
              bidx  <= '0;
              state <= S_DATA;
            end else begin
              // Start bit gone by its midpoint: a glitch, drop it silently.
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == FULL) begin
            timer <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bidx  <= bidx + 1'b1;
            if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (timer == FULL) begin
            timer <= '0;
            par   <= rx_s;
            state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leave at the stop midpoint so a following start edge is not missed.
          if (timer == FULL) begin
            timer  <= '0;
            state  <= S_IDLE;
            busy_q <= 1'b0;
            if (rx_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q  <= ^{shreg, par};
`endif
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
  assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx. Expected events come from frame
// start times and the byte sent; the monitor stamps every strobe by cycle.
module tb_uart_rx;
  localparam int C = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int LAT = 2 + C / 2 + (9 + PEN) * C;
  localparam int FL  = (10 + PEN) * C;

  typedef struct {
    int t;
    int k;   // 0 valid, 1 frame_err, 2 parity_err
    int d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_good = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  brise_q[$];
  int  bfall_q[$];
  logic busy_p = 1'b0;
  ev_t  mev;

  uart_rx_if bus ();
  uart_rx #(.CLOCK_RATE(10), .BAUD_RATE(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: stamp every strobe with the posedge that produced it.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      mev.t = cyc; mev.k = 0; mev.d = int'(bus.data); obs_q.push_back(mev);
    end
    if (bus.frame_err === 1'b1) begin
      mev.t = cyc; mev.k = 1; mev.d = 0; obs_q.push_back(mev);
    end
    if (bus.parity_err === 1'b1) begin
      mev.t = cyc; mev.k = 2; mev.d = 0; obs_q.push_back(mev);
    end
    if (bus.busy === 1'b1 && !busy_p) brise_q.push_back(cyc);
    if (bus.busy === 1'b0 && busy_p) bfall_q.push_back(cyc);
    busy_p <= (bus.busy === 1'b1);
  end

  task automatic chk(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic hold(input bit v, input int n);
    bus.rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input bit pflip, output int t0);
    t0 = cyc + 1;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(b[i], C);
    if (PEN != 0) hold((^b) ^ pflip, C);
    hold(stop, C);
  endtask

  // Reference: a frame starting at t0 resolves LAT clocks later.
  task automatic expect_frame(input int t0, input logic [7:0] b, input bit stop, input bit pflip);
    ev_t e;
    e.t = t0 + LAT;
    if (stop) begin
      e.k = 0; e.d = int'(b); exp_q.push_back(e);
      last_good = int'(b);
      if (PEN != 0 && pflip) begin
        e.k = 2; e.d = 0; exp_q.push_back(e);
      end
    end else begin
      e.k = 1; e.d = 0; exp_q.push_back(e);
    end
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_time"}, obs_q[i].t, exp_q[i].t);
      chk({tag, "_kind"}, obs_q[i].k, exp_q[i].k);
      chk({tag, "_data"}, obs_q[i].d, exp_q[i].d);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clr_busy();
    brise_q.delete();
    bfall_q.delete();
  endtask

  initial begin
    int t0, tg;
    int ts[5];
    logic [7:0] hello [5];
    logic [7:0] rb;
    bit rs, rp;
    int gap;

    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.valid), 0);
    rst = 1'b0;

    // 1: idle line
    hold(1'b1, 200);
    chk("idle_events", obs_q.size(), 0);
    chk("idle_busy_rises", brise_q.size(), 0);
    chk("idle_data", int'(bus.data), 0);
    chk("idle_perr", int'(bus.parity_err), 0);

    // 2: single byte, busy edges
    clr_busy();
    send(8'h48, 1'b1, 1'b0, t0);
    expect_frame(t0, 8'h48, 1'b1, 1'b0);
    hold(1'b1, 20);
    cmp_events("byte48");
    chk("byte48_brise_n", brise_q.size(), 1);
    chk("byte48_bfall_n", bfall_q.size(), 1);
    if (brise_q.size() > 0) chk("byte48_brise_t", brise_q[0], t0 + 3);
    if (bfall_q.size() > 0) chk("byte48_bfall_t", bfall_q[0], t0 + LAT);
    chk("byte48_data", int'(bus.data), 8'h48);
`ifdef UART_RX_PARITY_EN
    send(8'h48, 1'b1, 1'b1, t0);
    expect_frame(t0, 8'h48, 1'b1, 1'b1);
    hold(1'b1, 20);
    cmp_events("badpar");
`endif

    // 3: "Hello" with zero idle
    for (int i = 0; i < 5; i++) begin
      send(hello[i], 1'b1, 1'b0, ts[i]);
      expect_frame(ts[i], hello[i], 1'b1, 1'b0);
    end
    hold(1'b1, 20);
    for (int i = 1; i < 5 && i < obs_q.size(); i++)
      chk("hello_spacing", obs_q[i].t - obs_q[i-1].t, FL);
    cmp_events("hello");

    // 4: 3-cycle glitch, then a real frame
    clr_busy();
    tg = cyc + 1;
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("glitch_events", obs_q.size(), 0);
    chk("glitch_busy_rises", brise_q.size(), 1);
    if (brise_q.size() > 0) chk("glitch_brise_t", brise_q[0], tg + 3);
    send(8'h5A, 1'b1, 1'b0, t0);
    expect_frame(t0, 8'h5A, 1'b1, 1'b0);
    hold(1'b1, 20);
    cmp_events("byte5a");

    // 5: framing error with the line stuck low
    clr_busy();
    send(8'h55, 1'b0, 1'b0, t0);
    expect_frame(t0, 8'h55, 1'b0, 1'b0);
    hold(1'b0, 50);
    cmp_events("ferr");
    chk("ferr_data_held", int'(bus.data), last_good);
    chk("ferr_no_retrigger", brise_q.size(), 1);
    hold(1'b1, 10);
    chk("ferr_rise_no_busy", brise_q.size(), 1);

    // 6: reset during data bit 4 of 8'hF0 (line high from bit 4 on)
    clr_busy();
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(1'b0, C);
    hold(1'b1, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    last_good = 0;
    hold(1'b1, 80);
    chk("midrst_events", obs_q.size(), 0);
    chk("midrst_data", int'(bus.data), 0);
    send(8'hA5, 1'b1, 1'b0, t0);
    expect_frame(t0, 8'hA5, 1'b1, 1'b0);
    hold(1'b1, 20);
    cmp_events("byteA5");
    chk("byteA5_data", int'(bus.data), 8'hA5);

    // Random frames with random gaps, occasional bad stop / parity
    rs = 1'b1;
    for (int n = 0; n < 16; n++) begin
      gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      if (gap > 0) hold(1'b1, gap);
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      rp = ($urandom_range(0, 3) == 0);
      send(rb, rs, rp, t0);
      expect_frame(t0, rb, rs, rp);
    end
    hold(1'b1, 20);
    cmp_events("rand");
    chk("rand_data", int'(bus.data), last_good);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for 8N1 frames, the receive-side counterpart of the serial transmitter (`trigger`/`data`/`busy`/`tx`). It synchronises the asynchronous `rx` line, finds each start bit, and samples every bit at its midpoint using a clock-count timer. It then presents each correctly framed byte on `data` with a one-cycle `valid` strobe. It sits at the serial pin boundary and feeds byte-wide consumers.

## Interface
- `CLOCK_RATE`, default 10: clk frequency, in the same units as `BAUD_RATE`.
- `BAUD_RATE`, default 1: serial bit rate.
- `CLOCKS_PER_BIT`, default `CLOCK_RATE/BAUD_RATE`: clocks per serial bit. Must be ≥4; elaboration fails otherwise.

Ports:
- `clk` in, 1: single clock; all logic rises on its posedge.
- `rst` in, 1: synchronous, active-high reset.
- `rx` in, 1: asynchronous serial line; idle is high.
- `data` out, 8: last correctly framed byte, received LSB first.
- `valid` out, 1: one-cycle pulse when `data` updates.
- `busy` out, 1: high while a frame is being received.
- `frame_err` out, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` out, 1: one-cycle pulse on parity mismatch. Tied 0 when the parity macro is absent.

## Operation
- **Synchroniser.** `rx` passes through a 2-flop synchroniser (`rx_s`), followed by one history flop (`rx_d`). All three flops reset to 1.
- **State machine.** States are IDLE, START, DATA, PARITY (present only with the macro) and STOP.
- **IDLE.** A start is detected on a falling edge (`rx_d`=1, `rx_s`=0). On detection: clear the bit timer, go to START.
  - Detection is edge-based, so a line held low after an error never re-triggers.
- **START.** When the timer reaches `CLOCKS_PER_BIT/2 - 1`, sample `rx_s`.
  - If 0: clear the timer, clear the bit index, go to DATA.
  - If 1: treat as a glitch, return to IDLE, raise no flags.
- **DATA.** Every time the timer reaches `CLOCKS_PER_BIT - 1`, sample `rx_s`, clear the timer, and shift the bit into the MSB of the shift register (LSB-first frames).
  - After bit index 7, go to PARITY (macro defined) or STOP (macro absent).
- **PARITY.** After one bit period, sample and store the parity bit, then go to STOP.
- **STOP.** After one bit period, sample `rx_s`, then go to IDLE the same cycle. The outcome depends on the sample:
  - Stop = 1: `data` ← shift register, `valid` = 1 for one cycle. `parity_err` also pulses if parity mismatched.
  - Stop = 0: `frame_err` = 1 for one cycle; `valid` stays 0 and `data` is unchanged. Framing error takes precedence over a parity error.
- **Early return to IDLE.** Returning at the stop midpoint allows back-to-back frames with zero idle time.
- **`busy`.** High in every state except IDLE.
- **Reset values.** `data`=8'h00; `valid`, `busy`, `frame_err`, `parity_err` = 0; state IDLE; timer and bit index 0.
- **Reset mid-frame.** State returns to IDLE on the next edge with no pulses and `data` retained at 8'h00. The frame in progress is discarded, and a new falling edge is required to start again.

## Timing
- Let t0 be the first posedge at which `rx` is sampled low. Then:
  - `busy` rises at t0+3.
  - Each bit is sampled `CLOCKS_PER_BIT/2` clocks after its nominal start (integer division), plus the 2-cycle synchroniser delay.
- `valid` / `frame_err` assert at t0 + 2 + `CLOCKS_PER_BIT/2` + 9·`CLOCKS_PER_BIT` (plus one `CLOCKS_PER_BIT` with parity).
  - For `CLOCKS_PER_BIT`=10 this is t0+97 without parity, t0+107 with parity.
- `busy` falls in the same cycle that `valid`/`frame_err` asserts.
- `data` is stable from `valid` until the next `valid`.
- Baud tolerance is ±(`CLOCKS_PER_BIT/2` − 2) clocks of cumulative drift over the frame.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1. The PARITY state is compiled in; even parity is checked over the data bits plus the parity bit, and `parity_err` is live.
- `UART_RX_PARITY_EN` absent: frames are 8N1. No PARITY state; `parity_err` is a constant 0.

## Test plan
1. Reset, then `rx`=1 for 200 cycles → `valid`, `busy`, `frame_err` and `parity_err` stay 0; `data`=8'h00.
2. `CLOCKS_PER_BIT`=10, send 8'h48 → `busy` rises at t0+3, `valid` pulses exactly once at t0+97, `data`=8'h48.
   - With the macro: the same byte with a wrong parity bit gives `valid` and `parity_err` together at t0+107.
3. Send "Hello" back-to-back with zero idle → five `valid` pulses with `data` = 48, 65, 6C, 6C, 6F, spaced 100 cycles apart.
4. Drive `rx` low for 3 cycles, then high → `busy` pulses briefly; no `valid` and no `frame_err`; the next real frame 8'h5A is received.
5. Send 8'h55 with the stop bit held 0, then hold `rx` low for 50 cycles → one `frame_err` pulse, no `valid`, `data` holds its previous value, and no new `busy` until `rx` rises and then falls.
6. Assert `rst` for one cycle during data bit 4 → `busy` is 0 one cycle later, with no `valid`; a following frame 8'hA5 gives `data`=8'hA5.
